// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - producer-side and FIFO-side signals of the write-port arbiter
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ack;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic                          fifo_write_en;
  logic                          fifo_full;
  logic [$clog2(NUM_REQ)-1:0]    grant_id;
  logic                          locked;

  modport master (
    input  req, req_data, fifo_full,
    output req_ack, fifo_din, fifo_write_en, grant_id, locked
  );

  modport slave (
    output req, req_data, fifo_full,
    input  req_ack, fifo_din, fifo_write_en, grant_id, locked
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin write-port arbiter with burst locking for one sync FIFO
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic           clk,
  input  logic           reset,
  fifo_write_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  logic          lock_q, lock_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic [IW-1:0] rr_pick;
  logic [IW-1:0] g;
  logic          valid;
  logic          beat;

  // Modulo increment that also wraps correctly for non-power-of-2 NUM_REQ.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
  endfunction

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    rr_pick = rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (bus.req[idx]) rr_pick = IW'(idx);
    end
  end

  assign g     = lock_q ? owner_q : rr_pick;
  assign valid = lock_q ? bus.req[owner_q] : |bus.req;
  assign beat  = valid & ~bus.fifo_full & ~reset;

  assign bus.fifo_write_en = beat;
  assign bus.req_ack       = beat ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << g) : '0;
  assign bus.grant_id      = reset ? '0 : g;
  assign bus.fifo_din      = beat ? bus.req_data[int'(g)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.locked        = lock_q;

  always_comb begin
    lock_d     = lock_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (lock_q && !bus.req[owner_q]) begin
      lock_d     = 1'b0;
      rr_ptr_d   = wrap_inc(owner_q);
      beat_cnt_d = '0;
    end else if (beat && beat_cnt_q == CW'(MAX_BURST - 1)) begin
      lock_d     = 1'b0;
      rr_ptr_d   = wrap_inc(g);
      beat_cnt_d = '0;
    end else if (beat) begin
      lock_d     = 1'b1;
      owner_d    = g;
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q     <= 1'b0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed and randomized checks of fifo_write_arbiter against a reference model
module tb_fifo_write_arbiter;
  localparam int NA  = 4;
  localparam int MBA = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) ifa ();
  fifo_write_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8))  ifb ();

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  fifo_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  // Model: who holds the port, how many beats it has had, where the search starts.
  bit m_lock;
  int m_owner, m_ptr, m_cnt;

  logic [3:0]  obs_ack;
  logic [1:0]  obs_g;
  logic        obs_we, obs_locked;
  logic [31:0] words [4];
  logic [7:0]  wb [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step_a(input logic [3:0] rq, input logic full);
    int g;
    bit v, bt;
    ifa.req = rq;
    ifa.fifo_full = full;
    for (int i = 0; i < NA; i++) begin
      words[i] = $urandom;
      ifa.req_data[i*32 +: 32] = words[i];
    end
    #1;
    g = -1;
    if (m_lock) g = m_owner;
    else for (int k = 0; k < NA; k++) if (g < 0 && rq[(m_ptr + k) % NA]) g = (m_ptr + k) % NA;
    v  = m_lock ? rq[m_owner] : (rq != 4'b0);
    bt = v && !full;
    obs_ack = ifa.req_ack; obs_g = ifa.grant_id; obs_we = ifa.fifo_write_en; obs_locked = ifa.locked;
    chk("write_en", 64'(ifa.fifo_write_en), 64'(bt));
    chk("req_ack", 64'(ifa.req_ack), bt ? 64'(1 << g) : 64'd0);
    chk("fifo_din", 64'(ifa.fifo_din), bt ? 64'(words[g]) : 64'd0);
    chk("locked", 64'(ifa.locked), 64'(m_lock));
    if (g >= 0) chk("grant_id", 64'(ifa.grant_id), 64'(g));
    if (m_lock && !rq[m_owner]) begin
      m_lock = 0; m_ptr = (m_owner + 1) % NA; m_cnt = 0;
    end else if (bt) begin
      m_cnt++;
      if (m_cnt == MBA) begin
        m_lock = 0; m_cnt = 0; m_ptr = (g + 1) % NA;
      end else begin
        m_lock = 1; m_owner = g;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] rq;
    bit [5:0]   lock_seq;
    reset = 1'b1;
    ifa.req = '0; ifa.req_data = '0; ifa.fifo_full = 1'b0;
    ifb.req = '0; ifb.req_data = '0; ifb.fifo_full = 1'b0;
    model_reset();
    @(negedge clk);
    ifa.req = 4'b1111;
    #1;
    chk("rst_write_en", 64'(ifa.fifo_write_en), 64'd0);
    chk("rst_ack", 64'(ifa.req_ack), 64'd0);
    chk("rst_locked", 64'(ifa.locked), 64'd0);
    chk("rst_din", 64'(ifa.fifo_din), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // T1: single requester, bursts of 4 back to back
    do_reset();
    lock_seq = 6'b101110;
    for (int i = 0; i < 6; i++) begin
      step_a(4'b0001, 1'b0);
      chk("t1_ack", 64'(obs_ack), 64'd1);
      chk("t1_locked", 64'(obs_locked), 64'(lock_seq[i]));
    end

    // T2: all requesting, four beats each in rotation
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step_a(4'b1111, 1'b0);
      chk("t2_grant", 64'(obs_g), (i < 16) ? 64'(i / 4) : 64'd0);
    end

    // T3: stall mid-burst then resume
    do_reset();
    step_a(4'b0010, 1'b0);
    step_a(4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_a(4'b0010, 1'b1);
      chk("t3_stall_we", 64'(obs_we), 64'd0);
      chk("t3_stall_g", 64'(obs_g), 64'd1);
      chk("t3_stall_lock", 64'(obs_locked), 64'd1);
    end
    for (int i = 0; i < 2; i++) begin
      step_a(4'b0010, 1'b0);
      chk("t3_resume_ack", 64'(obs_ack), 64'b0010);
    end
    step_a(4'b0010, 1'b0);
    chk("t3_rotated", 64'(obs_locked), 64'd0);

    // T4: owner drops mid-burst
    do_reset();
    step_a(4'b1100, 1'b0);
    step_a(4'b1100, 1'b0);
    chk("t4_owner", 64'(obs_g), 64'd2);
    step_a(4'b1000, 1'b0);
    chk("t4_idle_we", 64'(obs_we), 64'd0);
    step_a(4'b1000, 1'b0);
    chk("t4_next_g", 64'(obs_g), 64'd3);
    chk("t4_next_ack", 64'(obs_ack), 64'b1000);

    // T5: asynchronous reset mid-burst
    do_reset();
    step_a(4'b1000, 1'b0);
    step_a(4'b1000, 1'b0);
    ifa.req = 4'b1111;
    #1;
    chk("t5_pre_we", 64'(ifa.fifo_write_en), 64'd1);
    chk("t5_pre_lock", 64'(ifa.locked), 64'd1);
    reset = 1'b1;
    #1;
    chk("t5_we", 64'(ifa.fifo_write_en), 64'd0);
    chk("t5_ack", 64'(ifa.req_ack), 64'd0);
    chk("t5_locked", 64'(ifa.locked), 64'd0);
    chk("t5_din", 64'(ifa.fifo_din), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step_a(4'b1111, 1'b0);
    chk("t5_first_g", 64'(obs_g), 64'd0);

    // T6: MAX_BURST=1 on three requesters
    do_reset();
    for (int i = 0; i < 7; i++) begin
      ifb.req = 3'b111;
      for (int j = 0; j < 3; j++) begin
        wb[j] = 8'($urandom);
        ifb.req_data[j*8 +: 8] = wb[j];
      end
      #1;
      chk("t6_grant", 64'(ifb.grant_id), 64'(i % 3));
      chk("t6_locked", 64'(ifb.locked), 64'd0);
      chk("t6_we", 64'(ifb.fifo_write_en), 64'd1);
      chk("t6_din", 64'(ifb.fifo_din), 64'(wb[i % 3]));
      @(negedge clk);
    end
    ifb.req = '0;

    // Randomized: sticky request patterns with occasional full stalls
    do_reset();
    rq = 4'($urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      step_a(rq, $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
